// File: rtl/frogger_player_fsm.sv
// Frog controller: edge-detected hops, log drift, goal scoring, lives, respawn delay
// and game-over/restart sequencing for a GRID_W x GRID_H playfield.
module frogger_player_fsm #(
    parameter int GRID_W         = 20,
    parameter int GRID_H         = 15,
    parameter int POS_W          = 6,
    parameter int SCORE_W        = 7,
    parameter int LIVES          = 3,
    parameter int LOG_DIV        = 39000000,
    parameter int RESPAWN_CYCLES = 25000000,
    parameter int GOAL_TILE      = 4,
    parameter int WATER_TILE     = 2
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Up_Mvt,
    input  logic               i_Down_Mvt,
    input  logic               i_Left_Mvt,
    input  logic               i_Right_Mvt,
    input  logic               i_Collided,
    input  logic [3:0]         i_Tile,
    input  logic               i_On_Log,
    input  logic               i_Log_Dir,
    output logic [POS_W-1:0]   o_Frogger_X,
    output logic [POS_W-1:0]   o_Frogger_Y,
    output logic [SCORE_W-1:0] o_Score,
    output logic [2:0]         o_Lives,
    output logic [1:0]         o_State,
    output logic               o_Death_Pulse
);

    typedef enum logic [1:0] {
        PLAY      = 2'b00,
        DYING     = 2'b01,
        GAME_OVER = 2'b10
    } state_e;

    localparam int DRIFT_W = (LOG_DIV > 1) ? $clog2(LOG_DIV) : 1;
    localparam int RESP_W  = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

    localparam logic [POS_W-1:0]   ORIGIN_X   = POS_W'(GRID_W / 2);
    localparam logic [POS_W-1:0]   ORIGIN_Y   = POS_W'(GRID_H - 1);
    localparam logic [POS_W-1:0]   X_MAX      = POS_W'(GRID_W - 1);
    localparam logic [DRIFT_W-1:0] DRIFT_LAST = DRIFT_W'(LOG_DIV - 1);
    localparam logic [RESP_W-1:0]  RESP_LOAD  = RESP_W'(RESPAWN_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [3:0]         GOAL_CODE  = 4'(GOAL_TILE);
    localparam logic [3:0]         WATER_CODE = 4'(WATER_TILE);

    state_e             state_q, state_d;
    logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic               pulse_q, pulse_d;
    logic [DRIFT_W-1:0] drift_q, drift_d;
    logic [RESP_W-1:0]  resp_q, resp_d;
    logic [3:0]         hist_q;

    logic [3:0] btn, hop_req;
    logic       tile_goal, tile_water, drift_tick, drift_at_edge, dies;

    // Button vector order {up, down, left, right} doubles as the hop priority.
    assign btn     = {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt};
    assign hop_req = btn & ~hist_q;

    assign tile_goal     = (i_Tile == GOAL_CODE);
    assign tile_water    = (i_Tile == WATER_CODE);
    assign drift_tick    = i_On_Log && (drift_q == DRIFT_LAST);
    assign drift_at_edge = i_Log_Dir ? (x_q == X_MAX) : (x_q == '0);
    assign dies          = i_Collided || (tile_water && !i_On_Log) ||
                           ((y_q == '0) && !tile_goal) || (drift_tick && drift_at_edge);

    // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= PLAY;
            x_q     <= ORIGIN_X;
            y_q     <= ORIGIN_Y;
            score_q <= '0;
            lives_q <= LIVES_INIT;
            pulse_q <= 1'b0;
            drift_q <= '0;
            resp_q  <= '0;
            // NOTE: history resets high so a button held through reset is not seen as a press.
            hist_q  <= 4'b1111;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            score_q <= score_d;
            lives_q <= lives_d;
            pulse_q <= pulse_d;
            drift_q <= drift_d;
            resp_q  <= resp_d;
            hist_q  <= btn;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        score_d = score_q;
        lives_d = lives_q;
        pulse_d = 1'b0;
        drift_d = '0;
        resp_d  = resp_q;
        unique case (state_q)
            PLAY: begin
                if (i_On_Log) drift_d = drift_tick ? '0 : drift_q + 1'b1;
                if (dies) begin
                    pulse_d = 1'b1;
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) begin
                        state_d = GAME_OVER;
                        x_d     = ORIGIN_X;
                        y_d     = ORIGIN_Y;
                    end else begin
                        state_d = DYING;
                        resp_d  = RESP_LOAD;
                    end
                end else if (y_q == '0) begin
                    score_d = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;
                    x_d     = ORIGIN_X;
                    y_d     = ORIGIN_Y;
                end else if (drift_tick) begin
                    x_d = i_Log_Dir ? x_q + 1'b1 : x_q - 1'b1;
                end else if (hop_req[3]) begin
                    if (y_q != '0) y_d = y_q - 1'b1;
                end else if (hop_req[2]) begin
                    if (y_q != ORIGIN_Y) y_d = y_q + 1'b1;
                end else if (hop_req[1]) begin
                    if (x_q != '0) x_d = x_q - 1'b1;
                end else if (hop_req[0]) begin
                    if (x_q != X_MAX) x_d = x_q + 1'b1;
                end
            end
            DYING: begin
                if (resp_q == '0) begin
                    state_d = PLAY;
                    x_d     = ORIGIN_X;
                    y_d     = ORIGIN_Y;
                end else begin
                    resp_d = resp_q - 1'b1;
                end
            end
            GAME_OVER: begin
                if (hop_req[3]) begin
                    state_d = PLAY;
                    score_d = '0;
                    lives_d = LIVES_INIT;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_comb begin
        o_Frogger_X   = x_q;
        o_Frogger_Y   = y_q;
        o_Score       = score_q;
        o_Lives       = lives_q;
        o_State       = state_q;
        o_Death_Pulse = pulse_q;
    end

endmodule

// File: doc/frogger_player_fsm.md
Name: frogger_player_fsm

Overview:
Parametrised next-generation frog controller. It covers grid-generic movement, correct per-button edge detection, lives, death and respawn sequencing, log riding in both directions, goal/bank detection, and game-over/restart. It sits between the button synchroniser/debouncer and the renderer/score display, and consumes tile and collision information from the playfield and traffic blocks.

Parameters:
GRID_W, 20, playfield columns; X range 0..GRID_W-1
GRID_H, 15, playfield rows; Y range 0..GRID_H-1, row 0 = goal bank
POS_W, 6, width of X/Y outputs; must satisfy 2^POS_W >= max(GRID_W, GRID_H)
SCORE_W, 7, score width; score saturates at 2^SCORE_W-1
LIVES, 3, lives at start and restart (1..7)
LOG_DIV, 39000000, clock cycles per one-tile log drift step
RESPAWN_CYCLES, 25000000, death-to-respawn delay in cycles
GOAL_TILE, 4, i_Tile code of a free goal slot
WATER_TILE, 2, i_Tile code of water

Ports:
i_Clk  in  1  system clock; all state on its rising edge
i_Rst_L  in  1  asynchronous active-low reset
i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt  in  1 each  synchronised, debounced button levels
i_Collided  in  1  frog overlaps a vehicle this cycle
i_Tile  in  4  tile code under the current frog position
i_On_Log  in  1  frog is standing on a log
i_Log_Dir  in  1  direction of the log under the frog: 1 = rightward, 0 = leftward
o_Frogger_X  out  POS_W  frog column, registered
o_Frogger_Y  out  POS_W  frog row, registered
o_Score  out  SCORE_W  goals reached
o_Lives  out  3  remaining lives
o_State  out  2  00 PLAY, 01 DYING, 10 GAME_OVER
o_Death_Pulse  out  1  one-cycle strobe on each death

Behaviour:
- Reset (async assert, sync-free release):
  - X = GRID_W/2, Y = GRID_H-1 (origin); score 0; lives LIVES; state PLAY; o_Death_Pulse 0.
  - All counters 0.
  - The four button history registers reset to 1, so a button held through reset does not hop.
- Edge detect:
  - One history register per button, each tracking its own button every cycle in every state.
  - A hop request is button==1 and history==0.
- PLAY, evaluated each cycle in this priority order; only the first matching item acts:
  1. Death: i_Collided, or (i_Tile==WATER_TILE and !i_On_Log), or (Y==0 and i_Tile!=GOAL_TILE).
  2. Goal: Y==0 and i_Tile==GOAL_TILE. Score +1, saturating. Frog returns to origin next cycle. Lives unchanged.
  3. Log drift tick: i_On_Log and drift counter == LOG_DIV-1.
     - Counter clears.
     - X moves +1 if i_Log_Dir else -1.
     - If X is already at the edge in the drift direction (GRID_W-1 or 0), this is a death.
     - Any hop request in this cycle is dropped.
  4. Hop: priority Up > Down > Left > Right.
     - Up Y-1 if Y>0; Down Y+1 if Y<GRID_H-1; Left X-1 if X>0; Right X+1 if X<GRID_W-1.
     - At the boundary the position holds; no wrap.
     - Latency: the position updates on the same edge that first samples the button high.
- Drift counter: increments while i_On_Log in PLAY; clears whenever !i_On_Log or state != PLAY.
- Death action, single cycle:
  - o_Death_Pulse = 1 for exactly one cycle.
  - Lives -1.
  - If the lives value after the decrement is 0: go to GAME_OVER. Otherwise go to DYING with the respawn counter loaded to RESPAWN_CYCLES-1.
  - Position freezes at the death location.
- DYING:
  - Hops, collisions and tiles are ignored.
  - Counter decrements each cycle. At 0: position goes to origin, state goes to PLAY.
  - Total time in DYING is RESPAWN_CYCLES cycles.
- GAME_OVER:
  - Position is held at origin (loaded on entry); score is frozen.
  - A hop request on Up restarts: score 0, lives LIVES, state PLAY. No movement occurs on the restart cycle.
- Reset asserted mid-DYING or GAME_OVER: immediate return to the reset values; no death pulse.
- Widths: X/Y arithmetic is done in POS_W bits; underflow is impossible because of the guards. o_Lives is never below 0.

Test Plan:
1. From reset, press Up 3 times, then hold Up for 10 cycles -> Y = 14,13,12,11 (one step per press). Hold produces no repeat. Left from X=0 stays at 0.
2. i_Collided pulse at (10,12), RESPAWN_CYCLES=3 -> o_Death_Pulse for 1 cycle, lives 3→2, state DYING for 3 cycles with hops ignored. Frog then at (10,14), state PLAY.
3. Frog at Y=1, press Up, i_Tile=GOAL_TILE at Y=0 -> score 0→1, frog at origin next cycle. Repeat with i_Tile=0 -> death, score unchanged. With score=127 and a goal -> score stays 127.
4. LOG_DIV=4, i_On_Log=1, i_Log_Dir=0, X=2 -> X=1 after 4 cycles, X=0 after 8 cycles, death at cycle 12. A Right press coinciding with a drift tick is dropped.
5. Three deaths from LIVES=3 -> after the third death: o_Lives=0, state GAME_OVER, Down/Left/Right have no effect. Up edge -> score 0, lives 3, PLAY at (10,14).
6. Water tile with i_On_Log=0 -> death. Assert i_Rst_L low mid-DYING -> all outputs take reset values asynchronously. Hold Up through reset release -> no hop.
